// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: merges hazard stalls, imem handshake, SYS halt and
// redirects into IF controls, holding redirects that land while IF is frozen.
module fetch_seq_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             pipe_stall,
   input  logic             sys_instr,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   input  logic             im_ready,
   output logic             im_req,
   output logic             if_stall,
   output logic             if_req_alt_pc,
   output logic [31:0]      if_alt_pc,
   output logic             redirect_pending,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0]  WC_ZERO  = {WC_W{1'b0}};
   localparam logic [WC_W-1:0]  WC_ONE   = {{(WC_W-1){1'b0}}, 1'b1};
   localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_WAIT = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t            state_r,      state_s;
   logic [WC_W-1:0]   wait_cnt_r,   wait_cnt_s;
   logic              pend_valid_r, pend_valid_s;
   logic [31:0]       pend_pc_r,    pend_pc_s;
   logic              mem_err_r,    mem_err_s;
   logic [CNT_W-1:0]  stall_cnt_r,  stall_cnt_s;

   logic              im_req_s;
   logic              if_stall_s;
   logic              req_alt_s;
   logic [31:0]       alt_pc_s;
   logic              timeout_s;

   // State and bookkeeping registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r      <= ST_RUN;
         wait_cnt_r   <= WC_ZERO;
         pend_valid_r <= 1'b0;
         pend_pc_r    <= 32'h0000_0000;
         mem_err_r    <= 1'b0;
         stall_cnt_r  <= CNT_ZERO;
      end else begin
         state_r      <= state_s;
         wait_cnt_r   <= wait_cnt_s;
         pend_valid_r <= pend_valid_s;
         pend_pc_r    <= pend_pc_s;
         mem_err_r    <= mem_err_s;
         stall_cnt_r  <= stall_cnt_s;
      end
   end

   // Same-cycle IF controls; a live redirect outranks the held one.
   always_comb begin
      im_req_s   = (state_r != ST_HALT);
      if_stall_s = (state_r == ST_HALT) | pipe_stall | (im_req_s & ~im_ready);
      req_alt_s  = ~if_stall_s & (redirect_valid | pend_valid_r);
      if (redirect_valid) begin
         alt_pc_s = redirect_pc;
      end else if (pend_valid_r) begin
         alt_pc_s = pend_pc_r;
      end else begin
         alt_pc_s = 32'h0000_0000;
      end
   end

   // The first low cycle is counted on RUN->WAIT, so WAIT ends at MEM_TIMEOUT-1.
   always_comb begin
      timeout_s = (state_r == ST_WAIT) & ~im_ready & (wait_cnt_r == WC_LAST);
   end

   // Next-state logic; a memory timeout overrides every other transition.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      mem_err_s  = mem_err_r;
      if (timeout_s) begin
         state_s    = ST_HALT;
         wait_cnt_s = WC_ZERO;
         mem_err_s  = 1'b1;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (redirect_valid & ~if_stall_s) begin
                  state_s = ST_RUN;
               end else if (sys_instr & ~if_stall_s) begin
                  state_s = ST_HALT;
               end else if (im_req_s & ~im_ready) begin
                  state_s    = ST_WAIT;
                  wait_cnt_s = WC_ONE;
               end else begin
                  state_s = ST_RUN;
               end
            end
            ST_WAIT: begin
               if (im_ready) begin
                  state_s    = ST_RUN;
                  wait_cnt_s = WC_ZERO;
               end else begin
                  wait_cnt_s = wait_cnt_r + WC_ONE;
               end
            end
            ST_HALT: begin
               if (redirect_valid) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_HALT;
               end
            end
            default: begin
               state_s    = ST_RUN;
               wait_cnt_s = WC_ZERO;
            end
         endcase
      end
   end

   // Pending-redirect slot: newest stalled redirect overwrites, delivery clears.
   always_comb begin
      pend_valid_s = pend_valid_r;
      pend_pc_s    = pend_pc_r;
      if (redirect_valid & if_stall_s) begin
         pend_valid_s = 1'b1;
         pend_pc_s    = redirect_pc;
      end else if (req_alt_s) begin
         pend_valid_s = 1'b0;
      end else begin
         pend_valid_s = pend_valid_r;
      end
   end

   // Saturating count of stalled cycles.
   always_comb begin
      if (if_stall_s & (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_s = stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_s = stall_cnt_r;
      end
   end

   assign im_req           = im_req_s;
   assign if_stall         = if_stall_s;
   assign if_req_alt_pc    = req_alt_s;
   assign if_alt_pc        = alt_pc_s;
   assign redirect_pending = pend_valid_r;
   assign halted           = (state_r == ST_HALT);
   assign mem_err          = mem_err_r;
   assign stall_cnt        = stall_cnt_r;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl; expected values are hand-computed per cycle.
module tb_fetch_seq_ctrl;

   localparam int MT = 16;
   localparam int CW = 16;

   logic          CLK;
   logic          RESET;
   logic          pipe_stall;
   logic          sys_instr;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          im_ready;
   logic          im_req;
   logic          if_stall;
   logic          if_req_alt_pc;
   logic [31:0]   if_alt_pc;
   logic          redirect_pending;
   logic          halted;
   logic          mem_err;
   logic [CW-1:0] stall_cnt;
   logic [5:0]    st_v;

   int n_cmp;
   int n_fail;

   fetch_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .pipe_stall       (pipe_stall),
      .sys_instr        (sys_instr),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .im_ready         (im_ready),
      .im_req           (im_req),
      .if_stall         (if_stall),
      .if_req_alt_pc    (if_req_alt_pc),
      .if_alt_pc        (if_alt_pc),
      .redirect_pending (redirect_pending),
      .halted           (halted),
      .mem_err          (mem_err),
      .stall_cnt        (stall_cnt)
   );

   // status = {if_stall, if_req_alt_pc, redirect_pending, halted, mem_err, im_req}
   assign st_v = {if_stall, if_req_alt_pc, redirect_pending, halted, mem_err, im_req};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic idle_inputs();
      pipe_stall     = 1'b0;
      sys_instr      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      im_ready       = 1'b1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      pipe_stall = 1'b1;
      RESET = 1'b0;
      #2;
      n_cmp++;
      if (st_v !== 6'b100001) begin
         n_fail++;
         $display("FAIL reset_status: got %b want %b", st_v, 6'b100001);
      end
      repeat (2) @(posedge CLK);
      #1;
      n_cmp++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
      pipe_stall = 1'b0;
      im_ready   = 1'b0;
      #1;
      n_cmp++;
      if (if_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_if_stall_not_ready: got %b want 1", if_stall);
      end
      im_ready = 1'b1;
      RESET    = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         #1;
         n_cmp++;
         if (st_v !== 6'b000001 || stall_cnt !== 16'd0 || if_alt_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL t1_idle c%0d: got st=%b cnt=%0d pc=%h want st=000001 cnt=0 pc=0",
                     c, st_v, stall_cnt, if_alt_pc);
         end
      end
   endtask

   task automatic test_stall_redirect();
      logic [5:0]  exp_st;
      logic [31:0] exp_pc;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         tick();
         idle_inputs();
         pipe_stall = (c >= 3 && c <= 5);
         if (c == 4) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h8000_0180;
         end
         #1;
         exp_st = {(c >= 3 && c <= 5), (c == 6), (c == 5 || c == 6), 1'b0, 1'b0, 1'b1};
         exp_pc = (c >= 4 && c <= 6) ? 32'h8000_0180 : 32'h0;
         n_cmp++;
         if (st_v !== exp_st) begin
            n_fail++;
            $display("FAIL t2_status c%0d: got %b want %b", c, st_v, exp_st);
         end
         n_cmp++;
         if (if_alt_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL t2_alt_pc c%0d: got %h want %h", c, if_alt_pc, exp_pc);
         end
      end
      n_cmp++;
      if (stall_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL t2_stall_cnt: got %0d want 3", stall_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  exp_st;
      logic [31:0] exp_pc;
      logic [31:0] issued_pc;
      int          issues;
      issues    = 0;
      issued_pc = 32'h0;
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         tick();
         idle_inputs();
         pipe_stall = (c <= 3);
         if (c == 1) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0100;
         end else if (c == 2) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0200;
         end else begin
            redirect_valid = 1'b0;
         end
         #1;
         if (if_req_alt_pc === 1'b1) begin
            issues++;
            issued_pc = if_alt_pc;
         end
         exp_st = {(c <= 3), (c == 4), (c >= 2 && c <= 4), 1'b0, 1'b0, 1'b1};
         exp_pc = (c == 1) ? 32'h0000_0100 : ((c >= 2 && c <= 4) ? 32'h0000_0200 : 32'h0);
         n_cmp++;
         if (st_v !== exp_st || if_alt_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL t3_cycle c%0d: got st=%b pc=%h want st=%b pc=%h",
                     c, st_v, if_alt_pc, exp_st, exp_pc);
         end
      end
      n_cmp++;
      if (issues !== 1 || issued_pc !== 32'h0000_0200) begin
         n_fail++;
         $display("FAIL t3_issue: got %0d issues pc=%h want 1 issue pc=00000200",
                  issues, issued_pc);
      end
   endtask

   task automatic test_mem_wait();
      logic [5:0] exp_st;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         tick();
         idle_inputs();
         im_ready = !(c >= 2 && c <= 4);
         #1;
         exp_st = {(c >= 2 && c <= 4), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         n_cmp++;
         if (st_v !== exp_st) begin
            n_fail++;
            $display("FAIL t4_status c%0d: got %b want %b", c, st_v, exp_st);
         end
      end
      n_cmp++;
      if (stall_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL t4_stall_cnt: got %0d want 3", stall_cnt);
      end
   endtask

   task automatic test_mem_timeout();
      // MT-1 low cycles must not trip the timeout.
      do_reset();
      for (int c = 1; c <= MT + 1; c++) begin
         tick();
         idle_inputs();
         im_ready = (c >= MT);
         #1;
      end
      n_cmp++;
      if (st_v !== 6'b000001) begin
         n_fail++;
         $display("FAIL t5_below_limit: got %b want 000001", st_v);
      end
      do_reset();
      for (int c = 1; c <= MT; c++) begin
         tick();
         idle_inputs();
         im_ready = 1'b0;
         #1;
         n_cmp++;
         if (st_v !== 6'b100001) begin
            n_fail++;
            $display("FAIL t5_waiting c%0d: got %b want 100001", c, st_v);
         end
      end
      for (int c = MT + 1; c <= MT + 6; c++) begin
         tick();
         idle_inputs();
         sys_instr  = (c == MT + 2);
         pipe_stall = (c == MT + 3);
         #1;
         n_cmp++;
         if (st_v !== 6'b100110) begin
            n_fail++;
            $display("FAIL t5_halted c%0d: got %b want 100110", c, st_v);
         end
      end
      RESET = 1'b0;
      #1;
      n_cmp++;
      if (st_v !== 6'b000001) begin
         n_fail++;
         $display("FAIL t5_reset_clears: got %b want 000001", st_v);
      end
      tick();
      RESET = 1'b1;
   endtask

   task automatic test_sys_halt();
      logic [5:0]  exp_st [1:8];
      logic [31:0] exp_pc [1:8];
      exp_st[1] = 6'b000001; exp_pc[1] = 32'h0;
      exp_st[2] = 6'b100100; exp_pc[2] = 32'h0;
      exp_st[3] = 6'b100100; exp_pc[3] = 32'hBFC0_0380;
      exp_st[4] = 6'b011001; exp_pc[4] = 32'hBFC0_0380;
      exp_st[5] = 6'b010001; exp_pc[5] = 32'h0000_1234;
      exp_st[6] = 6'b000001; exp_pc[6] = 32'h0;
      exp_st[7] = 6'b000001; exp_pc[7] = 32'h0;
      exp_st[8] = 6'b100100; exp_pc[8] = 32'h0;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         tick();
         idle_inputs();
         sys_instr  = (c == 1 || c == 5 || c == 7);
         pipe_stall = (c == 2);
         if (c == 3) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'hBFC0_0380;
         end else if (c == 5) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_1234;
         end else begin
            redirect_valid = 1'b0;
         end
         #1;
         n_cmp++;
         if (st_v !== exp_st[c] || if_alt_pc !== exp_pc[c]) begin
            n_fail++;
            $display("FAIL t6_cycle c%0d: got st=%b pc=%h want st=%b pc=%h",
                     c, st_v, if_alt_pc, exp_st[c], exp_pc[c]);
         end
      end
      RESET = 1'b0;
      #1;
      n_cmp++;
      if (st_v !== 6'b000001) begin
         n_fail++;
         $display("FAIL t6_reset_in_halt: got %b want 000001", st_v);
      end
      tick();
      RESET = 1'b1;
   endtask

   task automatic test_reset_midop();
      do_reset();
      tick();
      pipe_stall     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h55AA_00F0;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_cmp++;
      if (redirect_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL t7_captured: got %b want 1", redirect_pending);
      end
      RESET = 1'b0;
      #1;
      n_cmp++;
      if (redirect_pending !== 1'b0 || stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL t7_async_clear: got pend=%b cnt=%0d want pend=0 cnt=0",
                  redirect_pending, stall_cnt);
      end
      tick();
      idle_inputs();
      RESET = 1'b1;
      tick();
      #1;
      n_cmp++;
      if (st_v !== 6'b000001 || if_alt_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL t7_discarded: got st=%b pc=%h want st=000001 pc=0", st_v, if_alt_pc);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      RESET  = 1'b0;
      idle_inputs();
      test_reset();
      test_stall_redirect();
      test_back_to_back();
      test_mem_wait();
      test_mem_timeout();
      test_sys_halt();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
